// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch buffer:
//   - default width / depth constants
//   - request FSM state encoding (IDLE, WAIT_RESP, DROP)
//   - fetch entry record {pc, inst, fault} as seen by decode
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int DATA_W     = 64;  // PC / address width
  localparam int INST_W     = 32;  // instruction word width
  localparam int FIFO_DEPTH = 4;   // fetch buffer entries

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // free to issue a request
    WAIT_RESP = 2'd1,  // one request outstanding, response will be kept
    DROP      = 2'd2   // one request outstanding, response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding packed fetch entries.
//   clk          : clock
//   reset        : synchronous active-high reset (pointers and count to 0)
//   i_push       : write i_push_data at the tail
//   i_push_data  : entry to write
//   i_pop        : drop the head entry (caller guarantees count != 0)
//   i_flush      : empty the FIFO next cycle; wins over push and pop
//   o_count      : number of valid entries, 0..DEPTH
//   o_head       : head entry, read combinationally
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr_en;

  // A flushed push must not land in storage either, otherwise it would
  // reappear once the pointers catch up with it.
  assign w_wr_en = i_push && !i_flush && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_wr_en && (r_wr_ptr == AW'(gi))) begin
          r_mem[gi] <= i_push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_buffer.sv
// -----------------------------------------------------------------------------
// if_fetch_buffer
// Instruction-fetch stage: issues one-outstanding requests for currentPc,
// buffers returned {pc, inst, fault} entries and hands them to decode.
//   clk, reset        : clock, synchronous active-high reset
//   currentPc         : PC from the PC register
//   fetch_advance     : 1 when this cycle's fetch is accepted (PC may move)
//   flush             : branch redirect, drop buffered and in-flight fetches
//   imem_req_valid/_ready, imem_addr : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data    : response channel (no backpressure)
//   dec_valid/_ready, dec_pc, dec_inst, dec_fault : head entry to decode
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned currentPc is not
// sent to memory; a fault entry {currentPc, 0, 1} is pushed instead. Without
// it the address is forced word-aligned and dec_fault is always 0.
// -----------------------------------------------------------------------------
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int dataWidth = DATA_W,
  parameter int instWidth = INST_W,
  parameter int DEPTH     = FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [dataWidth-1:0] currentPc,
  output logic                 fetch_advance,
  input  logic                 flush,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [dataWidth-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [instWidth-1:0] imem_rsp_data,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [dataWidth-1:0] dec_pc,
  output logic [instWidth-1:0] dec_inst,
  output logic                 dec_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam int ENTRY_W = dataWidth + instWidth + 1;
`else
  localparam int ENTRY_W = dataWidth + instWidth;
`endif

  fetch_state_e         r_state;
  logic [dataWidth-1:0] r_addr;

  logic [CW-1:0]        w_count;
  logic [ENTRY_W-1:0]   w_head;
  logic [ENTRY_W-1:0]   w_push_data;
  logic                 w_can_issue;
  logic                 w_req_valid;
  logic                 w_req_fire;
  logic                 w_align_push;
  logic                 w_rsp_push;
  logic                 w_push;
  logic                 w_pop;

  // The count<DEPTH gate is what keeps the FIFO from overflowing: only one
  // request can be outstanding, so its response always finds a free slot.
  assign w_can_issue = !reset && (r_state == IDLE) && !flush &&
                       (w_count < CW'(DEPTH));

`ifdef FETCH_ALIGN_CHECK_EN
  logic w_misaligned;
  assign w_misaligned = (currentPc[1:0] != 2'b00);
  assign w_align_push = w_can_issue && w_misaligned;
  assign w_req_valid  = w_can_issue && !w_misaligned;
  assign imem_addr    = currentPc;
  assign w_push_data  = w_align_push ? {currentPc, {instWidth{1'b0}}, 1'b1}
                                     : {r_addr, imem_rsp_data, 1'b0};
`else
  assign w_align_push = 1'b0;
  assign w_req_valid  = w_can_issue;
  assign imem_addr    = {currentPc[dataWidth-1:2], 2'b00};
  assign w_push_data  = {r_addr, imem_rsp_data};
`endif

  assign w_req_fire    = w_req_valid && imem_req_ready;
  // A response that coincides with a flush belongs to the old path.
  assign w_rsp_push    = (r_state == WAIT_RESP) && imem_rsp_valid && !flush;
  assign w_push        = w_rsp_push || w_align_push;
  assign w_pop         = dec_valid && dec_ready;

  assign imem_req_valid = w_req_valid;
  assign fetch_advance  = w_req_fire || w_align_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_addr  <= currentPc;
            r_state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (imem_rsp_valid) begin
            r_state <= IDLE;
          end else if (flush) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign dec_valid = (w_count != '0);
  assign dec_pc    = w_head[ENTRY_W-1 -: dataWidth];
`ifdef FETCH_ALIGN_CHECK_EN
  assign dec_inst  = w_head[instWidth:1];
  // Qualified so an empty buffer never shows a stale fault bit.
  assign dec_fault = dec_valid && w_head[0];
`else
  assign dec_inst  = w_head[instWidth-1:0];
  assign dec_fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] currentPc = '0;
  logic        fetch_advance;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [63:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_fault;

  always #5 clk = ~clk;

  if_fetch_buffer dut (
    .clk(clk), .reset(reset), .currentPc(currentPc), .fetch_advance(fetch_advance),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_inst(dec_inst),
    .dec_fault(dec_fault)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] pc;
    bit          fl, rdy, rsp;
    logic [31:0] data;
    bit          drdy;
    bit          e_rv, e_adv, e_dv;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(logic [63:0] pc, bit fl, bit rdy, bit rsp, logic [31:0] data,
                              bit drdy, bit e_rv, bit e_adv, bit e_dv,
                              logic [63:0] e_pc, logic [31:0] e_inst);
    vec_t v;
    v.pc = pc; v.fl = fl; v.rdy = rdy; v.rsp = rsp; v.data = data; v.drdy = drdy;
    v.e_rv = e_rv; v.e_adv = e_adv; v.e_dv = e_dv; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  // ---------------- reference model ----------------
  fetch_entry_t q[$];
  bit          m_out, m_drop;
  logic [63:0] m_out_pc;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;
  logic [63:0] cur_pc;
  logic        obs_rv, obs_adv, obs_dv;
  logic [63:0] obs_addr, obs_dpc;

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
    dec_ready = 1'b1; currentPc = 64'h40;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_advance", fetch_advance, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_fault", dec_fault, 0);
    reset = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
    q.delete(); m_out = 0; m_drop = 0; mem_busy = 0; mem_cnt = 0;
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance the model.
  task automatic cyc(input bit fl, input bit rdy, input bit drdy, input int lat,
                     input bit spur, input logic [63:0] tgt);
    bit rsp, e_rv, e_align, e_adv, e_dv;
    logic [31:0] rdata;
    logic [63:0] e_addr;
    rsp   = mem_busy ? (mem_cnt == 1) : spur;
    rdata = (mem_busy && mem_cnt == 1) ? mem_data : $urandom;
    currentPc = cur_pc; flush = fl; imem_req_ready = rdy; dec_ready = drdy;
    imem_rsp_valid = rsp; imem_rsp_data = rdata;

    e_rv    = !m_out && !fl && (q.size() < FIFO_DEPTH);
    e_align = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    e_addr = cur_pc;
    if (cur_pc[1:0] != 2'b00) begin
      e_align = e_rv;
      e_rv    = 1'b0;
    end
`else
    e_addr = {cur_pc[63:2], 2'b00};
`endif
    e_adv = (e_rv && rdy) || e_align;
    e_dv  = (q.size() != 0);

    @(negedge clk);
    obs_rv = imem_req_valid; obs_adv = fetch_advance; obs_dv = dec_valid;
    obs_addr = imem_addr; obs_dpc = dec_pc;
    chk("req_valid", imem_req_valid, e_rv);
    chk("fetch_advance", fetch_advance, e_adv);
    chk("dec_valid", dec_valid, e_dv);
    if (e_rv) chk("imem_addr", imem_addr, e_addr);
    if (e_dv) begin
      chk("dec_pc", dec_pc, q[0].pc);
      chk("dec_inst", dec_inst, q[0].inst);
      chk("dec_fault", dec_fault, q[0].fault);
    end

    @(posedge clk);
    if (e_dv && drdy) void'(q.pop_front());
    if (fl) q.delete();
    else begin
      if (rsp && m_out && !m_drop) q.push_back('{pc: m_out_pc, inst: rdata, fault: 1'b0});
      if (e_align) q.push_back('{pc: cur_pc, inst: 32'h0, fault: 1'b1});
    end
    if (rsp && m_out) begin m_out = 0; m_drop = 0; end
    else if (fl && m_out) m_drop = 1;
    if (mem_busy) begin
      if (mem_cnt == 1) mem_busy = 0;
      else mem_cnt--;
    end
    if (e_rv && rdy) begin
      m_out = 1; m_drop = 0; m_out_pc = cur_pc;
      mem_busy = 1; mem_cnt = lat; mem_data = $urandom;
    end
    if (fl) cur_pc = tgt;
    else if (e_adv) cur_pc = cur_pc + 64'd4;
    #1;
  endtask

  initial begin
    vec_t tbl[13];
    // Fetch 0x1000 with 2-cycle latency, then a flush that must drop the
    // in-flight 0x2000 response before fetching the redirect target 0x3000.
    tbl[0]  = mk(64'h1000, 0, 1, 0, 32'h0,        1, 1, 1, 0, 64'h0,    32'h0);
    tbl[1]  = mk(64'h1004, 0, 1, 0, 32'h0,        1, 0, 0, 0, 64'h0,    32'h0);
    tbl[2]  = mk(64'h1004, 0, 1, 1, 32'hD503201F, 1, 0, 0, 0, 64'h0,    32'h0);
    tbl[3]  = mk(64'h1004, 0, 0, 0, 32'h0,        1, 1, 0, 1, 64'h1000, 32'hD503201F);
    tbl[4]  = mk(64'h1004, 0, 0, 0, 32'h0,        1, 1, 0, 0, 64'h0,    32'h0);
    tbl[5]  = mk(64'h2000, 0, 1, 0, 32'h0,        1, 1, 1, 0, 64'h0,    32'h0);
    tbl[6]  = mk(64'h2004, 1, 1, 0, 32'h0,        1, 0, 0, 0, 64'h0,    32'h0);
    tbl[7]  = mk(64'h3000, 0, 1, 0, 32'h0,        1, 0, 0, 0, 64'h0,    32'h0);
    tbl[8]  = mk(64'h3000, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0, 0, 64'h0,    32'h0);
    tbl[9]  = mk(64'h3000, 0, 1, 0, 32'h0,        1, 1, 1, 0, 64'h0,    32'h0);
    tbl[10] = mk(64'h3004, 0, 0, 1, 32'h11111111, 1, 0, 0, 0, 64'h0,    32'h0);
    tbl[11] = mk(64'h3004, 0, 0, 0, 32'h0,        0, 1, 0, 1, 64'h3000, 32'h11111111);
    tbl[12] = mk(64'h3004, 0, 0, 0, 32'h0,        1, 1, 0, 1, 64'h3000, 32'h11111111);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      currentPc = tbl[i].pc; flush = tbl[i].fl; imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rsp; imem_rsp_data = tbl[i].data; dec_ready = tbl[i].drdy;
      @(negedge clk);
      $display("vec %0d: pc=0x%0h rv=%0b adv=%0b dv=%0b dec_pc=0x%0h", i, tbl[i].pc,
               imem_req_valid, fetch_advance, dec_valid, dec_pc);
      chk($sformatf("vec%0d_req_valid", i), imem_req_valid, tbl[i].e_rv);
      chk($sformatf("vec%0d_advance", i), fetch_advance, tbl[i].e_adv);
      chk($sformatf("vec%0d_dec_valid", i), dec_valid, tbl[i].e_dv);
      if (tbl[i].e_dv) begin
        chk($sformatf("vec%0d_dec_pc", i), dec_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_dec_inst", i), dec_inst, tbl[i].e_inst);
      end
      @(posedge clk); #1;
    end

    // Fill to DEPTH with 1-cycle memory and decode stalled; the gate must close.
    do_reset();
    cur_pc = 64'h0;
    repeat (8) cyc(0, 1, 0, 1, 0, 64'h0);
    cyc(0, 1, 0, 1, 0, 64'h0);
    chk("full_gate", obs_rv, 0);
    chk("full_head_pc", obs_dpc, 64'h0);
    cyc(0, 1, 1, 1, 0, 64'h0);  // pop one
    cyc(0, 1, 0, 1, 0, 64'h0);
    chk("refill_req", obs_rv, 1);
    chk("refill_addr", obs_addr, 64'h10);
    $display("seq full: refill addr=0x%0h", obs_addr);

    // Steady push+pop at count 2 for 10 cycles (covers pointer wrap).
    do_reset();
    cur_pc = 64'h800;
    repeat (4) cyc(0, 1, 0, 1, 0, 64'h0);
    for (int i = 0; i < 10; i++) cyc(0, 1, (i % 2) == 1, 1, 0, 64'h0);
    chk("steady_count2_valid", obs_dv, 1);
    $display("seq steady: head pc=0x%0h", obs_dpc);

    // Flush coinciding with a response, 2 entries buffered.
    do_reset();
    cur_pc = 64'h100;
    repeat (4) cyc(0, 1, 0, 1, 0, 64'h0);
    cyc(0, 1, 0, 2, 0, 64'h0);
    cyc(0, 1, 0, 1, 0, 64'h0);
    cyc(1, 1, 0, 1, 0, 64'h5000);
    chk("flushrsp_noreq", obs_rv, 0);
    cyc(0, 1, 0, 1, 0, 64'h0);
    chk("flushrsp_empty", obs_dv, 0);
    chk("flushrsp_newaddr", obs_addr, 64'h5000);
    $display("seq flush+rsp: dec_valid=%0b next addr=0x%0h", obs_dv, obs_addr);

    // Misaligned PC.
    do_reset();
    cur_pc = 64'h1002;
    cyc(0, 1, 0, 2, 0, 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_noreq", obs_rv, 0);
    chk("mis_advance", obs_adv, 1);
    cyc(0, 0, 0, 1, 0, 64'h0);
    chk("mis_entry_valid", obs_dv, 1);
    chk("mis_entry_pc", obs_dpc, 64'h1002);
`else
    chk("mis_addr_aligned", obs_addr, 64'h1000);
    cyc(0, 0, 0, 1, 0, 64'h0);
    cyc(0, 0, 0, 1, 0, 64'h0);
    cyc(0, 0, 0, 1, 0, 64'h0);
    chk("mis_dec_pc_full", obs_dpc, 64'h1002);
`endif
    $display("seq misaligned: head pc=0x%0h", obs_dpc);

    // Randomized traffic against the model, with a reset in the middle.
    do_reset();
    cur_pc = 64'h4000;
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      t[1:0] = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
      if (i == 1500) begin
        do_reset();
        cur_pc = 64'h8000;
      end
      cyc(($urandom % 20) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
          int'($urandom_range(1, 4)), ($urandom % 8) == 0, t);
    end
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
